// File: rtl/biriscv_trace_arb.sv
// Dual-issue retire trace arbiter: packs up to two retiring instructions per cycle
// into a sequence-numbered FIFO feeding the trace decoder, dropping whole cycles on overflow.
module biriscv_trace_arb #(
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       enable_i,
    input  logic                       flush_i,
    input  logic                       pipe0_valid_i,
    input  logic [31:0]                pipe0_pc_i,
    input  logic [31:0]                pipe0_opcode_i,
    input  logic                       pipe1_valid_i,
    input  logic [31:0]                pipe1_pc_i,
    input  logic [31:0]                pipe1_opcode_i,
    output logic                       trace_valid_o,
    output logic [31:0]                trace_pc_o,
    output logic [31:0]                trace_opcode_o,
    output logic [15:0]                trace_seq_o,
    input  logic                       trace_ready_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o,
    output logic [15:0]                drop_count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [31:0]   pc_mem  [DEPTH];
    logic [31:0]   op_mem  [DEPTH];
    logic [15:0]   seq_mem [DEPTH];

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [15:0]   seq_q;
    logic          overflow_q;
    logic [15:0]   drop_count_q;

    logic          push_en;
    logic [1:0]    n_cand;
    logic [LW-1:0] space;
    logic          accept;
    logic          drop;
    logic          pop;
    logic [1:0]    acc_n;
    logic [AW-1:0] wr_idx1;
    logic [15:0]   seq1;
    logic [16:0]   drop_sum;

    assign push_en = enable_i && !flush_i;
    assign n_cand  = {1'b0, pipe0_valid_i} + {1'b0, pipe1_valid_i};
    // Room is judged on the start-of-cycle level; a same-cycle pop never makes space.
    assign space   = LW'(DEPTH) - level_q;
    assign accept  = push_en && (n_cand != 2'd0) && (space >= LW'(n_cand));
    assign drop    = push_en && (n_cand != 2'd0) && !accept;
    assign pop     = (level_q != '0) && trace_ready_i && !flush_i;
    assign acc_n   = accept ? n_cand : 2'd0;

    // pipe1 lands behind pipe0 when both retire, otherwise it takes the write slot itself.
    assign wr_idx1  = pipe0_valid_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
    assign seq1     = pipe0_valid_i ? seq_q + 16'd1 : seq_q;
    assign drop_sum = {1'b0, drop_count_q} + 17'(n_cand);

    always_ff @(posedge clk_i) begin
        if (accept) begin
            if (pipe0_valid_i) begin
                pc_mem[wr_ptr_q]  <= pipe0_pc_i;
                op_mem[wr_ptr_q]  <= pipe0_opcode_i;
                seq_mem[wr_ptr_q] <= seq_q;
            end
            if (pipe1_valid_i) begin
                pc_mem[wr_idx1]  <= pipe1_pc_i;
                op_mem[wr_idx1]  <= pipe1_opcode_i;
                seq_mem[wr_idx1] <= seq1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            seq_q        <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(acc_n);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            level_q  <= level_q + LW'(acc_n) - LW'(pop);
            if (push_en) begin
                seq_q <= seq_q + 16'(n_cand);
            end
            if (drop) begin
                overflow_q   <= 1'b1;
                drop_count_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
        end
    end

    assign trace_valid_o  = (level_q != '0);
    assign trace_pc_o     = pc_mem[rd_ptr_q];
    assign trace_opcode_o = op_mem[rd_ptr_q];
    assign trace_seq_o    = seq_mem[rd_ptr_q];
    assign level_o        = level_q;
    assign overflow_o     = overflow_q;
    assign drop_count_o   = drop_count_q;

endmodule

// File: doc/biriscv_trace_arb.md
BIRISCV_TRACE_ARB -- requirements
Module: biriscv_trace_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 8, giving the FIFO entry count; legal values are powers of two from 4 to 64.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port enable_i, input, 1 bit: trace capture enable.
REQ-005 SHALL have port flush_i, input, 1 bit: synchronous clear of FIFO and statistics.
REQ-006 SHALL have ports pipe0_valid_i (1 bit), pipe0_pc_i (32 bits) and pipe0_opcode_i (32 bits), all inputs: the older retiring instruction.
REQ-007 SHALL have ports pipe1_valid_i (1 bit), pipe1_pc_i (32 bits) and pipe1_opcode_i (32 bits), all inputs: the younger retiring instruction of the same cycle.
REQ-008 SHALL have ports trace_valid_o (1 bit), trace_pc_o (32 bits), trace_opcode_o (32 bits) and trace_seq_o (16 bits), all outputs: the head record offered to the trace decoder.
REQ-009 SHALL have port trace_ready_i, input, 1 bit: the sink accepts the head record.
REQ-010 SHALL have port level_o, output, log2(DEPTH)+1 bits: current FIFO occupancy.
REQ-011 SHALL have port overflow_o, output, 1 bit: sticky flag, set when any record has been dropped.
REQ-012 SHALL have port drop_count_o, output, 16 bits: count of dropped records, saturating.

Function
REQ-013 SHALL evaluate a push only when enable_i=1 and flush_i=0; push candidates are those pipeN_valid_i that are high, n = 0, 1 or 2.
REQ-014 SHALL write the candidates in program order, pipe0 before pipe1; when only pipe1 is valid, pipe1 occupies one slot.
REQ-015 SHALL accept a cycle's candidates only if (DEPTH - level at start of cycle) >= n; a pop in the same cycle SHALL NOT create room for that cycle's push.
REQ-016 SHALL drop all n candidates when space is insufficient (all-or-nothing per cycle), set overflow_o, and add n to drop_count_o, saturating at 0xFFFF.
REQ-017 SHALL keep a 16-bit sequence counter and give each candidate the current value, pipe0 first; the counter SHALL advance by n on both accept and drop, so a dropped record appears as a gap in trace_seq_o; the counter wraps at 0xFFFF to 0x0000.
REQ-018 SHALL store {pc, opcode, seq} per FIFO entry.
REQ-019 SHALL drive trace_valid_o = (level != 0); trace_pc_o, trace_opcode_o and trace_seq_o SHALL show the head entry.
REQ-020 SHALL pop the head when trace_valid_o=1 and trace_ready_i=1 in the same cycle.
REQ-021 SHALL keep all trace_*_o outputs stable while trace_valid_o=1 and trace_ready_i=0.
REQ-022 SHALL have a latency of one cycle: a record pushed at edge N is visible on the outputs after edge N, and is poppable in cycle N+1.
REQ-023 SHALL update level as level + accepted - popped; accepting 2 and popping 1 in the same cycle gives a net change of +1.
REQ-024 SHALL wrap the read and write pointers modulo DEPTH; full is level == DEPTH and empty is level == 0.
REQ-025 SHALL, when flush_i=1, clear the pointers, level, overflow_o and drop_count_o; the push and pop of that cycle are ignored; the sequence counter SHALL NOT be cleared.
REQ-026 SHALL, when enable_i=0, ignore pipe inputs, leave counters and the sequence counter unchanged, and continue draining the FIFO.
REQ-027 SHALL leave the outputs driven by stale FIFO entries when trace_valid_o=0; these outputs are don't-care and SHALL NOT be checked.

Reset
REQ-028 SHALL, while rst_ni=0, asynchronously force level=0, the pointers to 0, the sequence counter to 0, trace_valid_o=0, overflow_o=0 and drop_count_o=0.
REQ-029 SHALL discard any FIFO content when reset is asserted mid-operation; memory contents need no reset.
REQ-030 SHALL begin normal operation at the first rising edge after rst_ni deasserts.

Verification
REQ-031 SHALL cover dual push: pipe0 (pc 0x100, op 0x00000013) and pipe1 (pc 0x104, op 0x00100093) with ready=1 -> outputs 0x100 with seq 0, then 0x104 with seq 1, on consecutive cycles.
REQ-032 SHALL cover backpressure: ready=0, DEPTH=8, four dual pushes -> level=8; a fifth dual push -> dropped, drop_count_o=2, overflow_o=1; on drain, seq values 0-7 appear, then the next accepted record carries seq 10.
REQ-033 SHALL cover the boundary: level=7, dual push with a simultaneous pop -> both dropped and level=6; level=6 under the same stimulus -> both accepted and level=7.
REQ-034 SHALL cover flush: flush_i pulsed with level=5 and drop_count_o=3 -> next cycle level=0, trace_valid_o=0, drop_count_o=0; the sequence counter continues from its prior value.
REQ-035 SHALL cover reset: rst_ni driven low mid-drain with level=4 -> outputs reach reset values immediately without a clock edge; after release, the first push gets seq 0.
REQ-036 SHALL cover the wrap cases: 70000 single pushes at ready=1 -> trace_seq_o wraps from 0xFFFF to 0x0000 with no gap; drop_count_o driven past 65535 holds at 0xFFFF.
